change_dispenser: RTL and testbench

Coin-change dispenser that consumes the per-sale result of the vending controller (soda strobe plus 3-bit change code) and pays the change out through a coin hopper, one coin at a time, over a request/acknowledge handshake. It sits directly downstream of the vending controller and directly upstream of the hopper driver. It also issues the soda-drop strobe and buffers one pending sale while a payout is in progress.

---
 rtl/change_dispenser_if.sv | 29 ++
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 tb/tb_change_dispenser.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: sale, hopper handshake and status signals of the dispenser.
// master drives the sale/hopper inputs; slave (the dispenser) drives the status outputs.
interface change_dispenser_if;
  logic       i_soda;
  logic [2:0] i_change;
  logic       i_dime_empty;
  logic       i_hopper_ack;
  logic       o_vend;
  logic       o_nickel_req;
  logic       o_dime_req;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_remaining;
  logic       o_drop;
  logic       o_err;
  logic       o_fault;

  modport master (
    output i_soda, i_change, i_dime_empty, i_hopper_ack,
    input  o_vend, o_nickel_req, o_dime_req, o_busy, o_done,
    input  o_remaining, o_drop, o_err, o_fault
  );

  modport slave (
    input  i_soda, i_change, i_dime_empty, i_hopper_ack,
    output o_vend, o_nickel_req, o_dime_req, o_busy, o_done,
    output o_remaining, o_drop, o_err, o_fault
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: vends per sale, pays change one coin at a time over the hopper
// req/ack handshake, buffers one pending sale.
// Ports: i_clk, i_rst_n (async, active-low), bus (change_dispenser_if.slave).
// Option: CHANGE_DISPENSER_TIMEOUT_EN adds the MAX_WAIT ack timeout and o_fault.
module change_dispenser #(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_WAIT   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  change_dispenser_if.slave bus
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
      MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_param
    $error("change_dispenser: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, START, REQ, GAP, DONE
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic       pend_valid;
  logic [2:0] pend_code;
  logic [3:0] gap_cnt;

  logic       illegal;
  logic [2:0] code_in;
  logic       pick_dime;
  logic       acked;
  logic [2:0] rem_next;
  logic       stash;
  logic       expired;

  // Illegal codes still vend, but owe nothing.
  assign illegal   = bus.i_change > 3'd4;
  assign code_in   = illegal ? 3'd0 : bus.i_change;
  assign pick_dime = bus.o_remaining >= 3'd2 && !bus.i_dime_empty;
  assign acked     = bus.i_hopper_ack &&
                     (bus.o_nickel_req || bus.o_dime_req);
  assign rem_next  = bus.o_remaining -
                     (bus.o_dime_req ? 3'd2 : 3'd1);
  // DONE hands sales over itself, so only these states use the slot.
  assign stash     = bus.i_soda &&
                     (state == START || state == REQ || state == GAP);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  logic [7:0] wait_cnt;
  logic       fault;
  assign expired     = state == REQ && wait_cnt == WAIT_LAST;
  assign bus.o_fault = fault;
`else
  assign expired     = 1'b0;
  assign bus.o_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      pend_valid       <= 1'b0;
      pend_code        <= 3'd0;
      gap_cnt          <= 4'd0;
      bus.o_vend       <= 1'b0;
      bus.o_nickel_req <= 1'b0;
      bus.o_dime_req   <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_remaining  <= 3'd0;
      bus.o_drop       <= 1'b0;
      bus.o_err        <= 1'b0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      wait_cnt         <= 8'd0;
      fault            <= 1'b0;
`endif
    end else begin
      bus.o_vend <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_drop <= 1'b0;
      bus.o_err  <= bus.i_soda && illegal;
      if (stash) begin
        if (pend_valid) begin
          bus.o_drop <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_code  <= code_in;
        end
      end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      // Zero outside REQ, so every new request starts from zero.
      wait_cnt <= (state == REQ) ? wait_cnt + 8'd1 : 8'd0;
`endif
      unique case (state)
        IDLE: begin
          if (bus.i_soda) begin
            state           <= START;
            bus.o_remaining <= code_in;
            bus.o_vend      <= 1'b1;
            bus.o_busy      <= 1'b1;
          end
        end
        START: begin
          if (bus.o_remaining != 3'd0) begin
            state            <= REQ;
            bus.o_dime_req   <= pick_dime;
            bus.o_nickel_req <= !pick_dime;
          end else begin
            state      <= DONE;
            bus.o_done <= 1'b1;
          end
        end
        REQ: begin
          if (acked) begin
            bus.o_nickel_req <= 1'b0;
            bus.o_dime_req   <= 1'b0;
            bus.o_remaining  <= rem_next;
            if (rem_next != 3'd0) begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
            end else begin
              state      <= DONE;
              bus.o_done <= 1'b1;
            end
          end else if (expired) begin
            bus.o_nickel_req <= 1'b0;
            bus.o_dime_req   <= 1'b0;
            bus.o_remaining  <= 3'd0;
            state            <= DONE;
            bus.o_done       <= 1'b1;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
            fault            <= 1'b1;
`endif
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state            <= REQ;
            bus.o_dime_req   <= pick_dime;
            bus.o_nickel_req <= !pick_dime;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        DONE: begin
          if (pend_valid) begin
            // Slot frees as it loads; a sale this cycle refills it.
            state           <= START;
            bus.o_remaining <= pend_code;
            bus.o_vend      <= 1'b1;
            pend_valid      <= bus.i_soda;
            pend_code       <= code_in;
          end else if (bus.i_soda) begin
            state           <= START;
            bus.o_remaining <= code_in;
            bus.o_vend      <= 1'b1;
          end else begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios plus randomized sales checked
// against a coin-level payout model.
module tb_change_dispenser;
  localparam int GAP = 4;
  localparam int MW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  change_dispenser_if bus();

  change_dispenser #(
    .GAP_CYCLES(GAP),
    .MAX_WAIT(MW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   vend_n = 0;
  int   done_n = 0;
  int   drop_n = 0;
  int   nick_n = 0;
  int   dime_n = 0;
  logic pn = 1'b0;
  logic pd = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      vend_n <= vend_n + int'(bus.o_vend);
      done_n <= done_n + int'(bus.o_done);
      drop_n <= drop_n + int'(bus.o_drop);
      nick_n <= nick_n + int'(bus.o_nickel_req && !pn);
      dime_n <= dime_n + int'(bus.o_dime_req && !pd);
    end
    pn <= bus.o_nickel_req;
    pd <= bus.o_dime_req;
  end

  function automatic logic [10:0] outs();
    return {bus.o_vend, bus.o_nickel_req, bus.o_dime_req,
            bus.o_busy, bus.o_done, bus.o_remaining,
            bus.o_drop, bus.o_err, bus.o_fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sale(input int code);
    bus.i_change = 3'(code);
    bus.i_soda = 1'b1;
    tick();
    bus.i_soda = 1'b0;
    bus.i_change = 3'($urandom_range(0, 7));
  endtask

  // Acks every request as soon as it is seen; stops once idle.
  task automatic run_auto(input int budget, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      bus.i_hopper_ack = bus.o_nickel_req | bus.o_dime_req;
      tick();
      n++;
      if (!bus.o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.i_hopper_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_soda = 1'b0;
    bus.i_change = 3'd0;
    bus.i_dime_empty = 1'b0;
    bus.i_hopper_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0", outs());
    end
    rst_n = 1'b1;
    bus.i_hopper_ack = 1'b1;
    bus.i_change = 3'd3;
    tick();
    tick();
    bus.i_hopper_ack = 1'b0;
    checks++;
    if (outs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0", outs());
    end
  endtask

  task automatic test_code3();
    int n;
    bus.i_dime_empty = 1'b0;
    sale(3);
    checks++;
    if ({bus.o_vend, bus.o_busy, bus.o_remaining} !== 5'b11_011) begin
      failures++;
      $display("FAIL c3_vend got=%b exp=11011",
               {bus.o_vend, bus.o_busy, bus.o_remaining});
    end
    tick();
    checks++;
    if ({bus.o_dime_req, bus.o_nickel_req} !== 2'b10) begin
      failures++;
      $display("FAIL c3_dime got=%b exp=10",
               {bus.o_dime_req, bus.o_nickel_req});
    end
    tick();
    bus.i_hopper_ack = 1'b1;
    tick();
    bus.i_hopper_ack = 1'b0;
    checks++;
    if ({bus.o_dime_req, bus.o_nickel_req, bus.o_remaining} !== 5'b00_001) begin
      failures++;
      $display("FAIL c3_ack1 got=%b exp=00001",
               {bus.o_dime_req, bus.o_nickel_req, bus.o_remaining});
    end
    n = 0;
    while (!(bus.o_nickel_req || bus.o_dime_req) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != GAP) begin
      failures++;
      $display("FAIL c3_gap got=%0d exp=%0d", n, GAP);
    end
    checks++;
    if ({bus.o_dime_req, bus.o_nickel_req} !== 2'b01) begin
      failures++;
      $display("FAIL c3_nickel got=%b exp=01",
               {bus.o_dime_req, bus.o_nickel_req});
    end
    tick();
    bus.i_hopper_ack = 1'b1;
    tick();
    bus.i_hopper_ack = 1'b0;
    checks++;
    if ({bus.o_done, bus.o_nickel_req, bus.o_remaining} !== 5'b10_000) begin
      failures++;
      $display("FAIL c3_done got=%b exp=10000",
               {bus.o_done, bus.o_nickel_req, bus.o_remaining});
    end
    tick();
    checks++;
    if ({bus.o_busy, bus.o_done} !== 2'b00) begin
      failures++;
      $display("FAIL c3_idle got=%b exp=00", {bus.o_busy, bus.o_done});
    end
  endtask

  task automatic test_nodime();
    int n0, d0, dn0;
    bit ok;
    n0 = nick_n;
    d0 = dime_n;
    dn0 = done_n;
    bus.i_dime_empty = 1'b1;
    sale(4);
    run_auto(200, ok);
    bus.i_dime_empty = 1'b0;
    checks++;
    if (!ok || nick_n - n0 != 4 || dime_n - d0 != 0 || done_n - dn0 != 1) begin
      failures++;
      $display("FAIL nodime ok=%0d nick=%0d dime=%0d done=%0d exp 1/4/0/1",
               ok, nick_n - n0, dime_n - d0, done_n - dn0);
    end
  endtask

  task automatic test_zero_then_sale();
    int v0, n0, d0;
    bit ok;
    v0 = vend_n;
    n0 = nick_n;
    d0 = dime_n;
    bus.i_dime_empty = 1'b0;
    sale(0);
    tick();
    checks++;
    if ({bus.o_done, bus.o_busy} !== 2'b11) begin
      failures++;
      $display("FAIL zero_done got=%b exp=11", {bus.o_done, bus.o_busy});
    end
    sale(2);
    checks++;
    if ({bus.o_vend, bus.o_done, bus.o_remaining} !== 5'b10_010) begin
      failures++;
      $display("FAIL zero_next_vend got=%b exp=10010",
               {bus.o_vend, bus.o_done, bus.o_remaining});
    end
    run_auto(100, ok);
    checks++;
    if (!ok || vend_n - v0 != 2 || dime_n - d0 != 1 || nick_n - n0 != 0) begin
      failures++;
      $display("FAIL zero_pay ok=%0d vend=%0d dime=%0d nick=%0d exp 1/2/1/0",
               ok, vend_n - v0, dime_n - d0, nick_n - n0);
    end
  endtask

  task automatic test_overflow();
    int v0, dr0, dn0, n0, d0;
    bit ok;
    v0 = vend_n;
    dr0 = drop_n;
    dn0 = done_n;
    n0 = nick_n;
    d0 = dime_n;
    bus.i_dime_empty = 1'b0;
    sale(2);
    sale(1);
    sale(3);
    checks++;
    if (bus.o_drop !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop got=%b exp=1", bus.o_drop);
    end
    tick();
    checks++;
    if (bus.o_drop !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drop_pulse got=%b exp=0", bus.o_drop);
    end
    run_auto(200, ok);
    checks++;
    if (!ok || vend_n - v0 != 2 || drop_n - dr0 != 1 || done_n - dn0 != 2 ||
        dime_n - d0 != 1 || nick_n - n0 != 1) begin
      failures++;
      $display("FAIL ovf_counts ok=%0d vend=%0d drop=%0d done=%0d dime=%0d nick=%0d exp 1/2/1/2/1/1",
               ok, vend_n - v0, drop_n - dr0, done_n - dn0,
               dime_n - d0, nick_n - n0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, dr0, dn0;
    bit ok;
    v0 = vend_n;
    dr0 = drop_n;
    dn0 = done_n;
    bus.i_dime_empty = 1'b0;
    sale(1);
    sale(0);
    bus.i_hopper_ack = 1'b1;
    tick();
    bus.i_hopper_ack = 1'b0;
    checks++;
    if ({bus.o_done, bus.o_nickel_req} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=10", {bus.o_done, bus.o_nickel_req});
    end
    sale(0);
    checks++;
    if ({bus.o_vend, bus.o_drop, bus.o_busy} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_vend got=%b exp=101",
               {bus.o_vend, bus.o_drop, bus.o_busy});
    end
    run_auto(100, ok);
    checks++;
    if (!ok || vend_n - v0 != 3 || done_n - dn0 != 3 || drop_n - dr0 != 0) begin
      failures++;
      $display("FAIL b2b_counts ok=%0d vend=%0d done=%0d drop=%0d exp 1/3/3/0",
               ok, vend_n - v0, done_n - dn0, drop_n - dr0);
    end
  endtask

  task automatic test_illegal();
    int n0, d0;
    n0 = nick_n;
    d0 = dime_n;
    sale(6);
    checks++;
    if ({bus.o_vend, bus.o_err, bus.o_remaining} !== 5'b11_000) begin
      failures++;
      $display("FAIL ill_vend got=%b exp=11000",
               {bus.o_vend, bus.o_err, bus.o_remaining});
    end
    tick();
    checks++;
    if ({bus.o_done, bus.o_err, bus.o_nickel_req, bus.o_dime_req} !== 4'b1000) begin
      failures++;
      $display("FAIL ill_done got=%b exp=1000",
               {bus.o_done, bus.o_err, bus.o_nickel_req, bus.o_dime_req});
    end
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || nick_n != n0 || dime_n != d0) begin
      failures++;
      $display("FAIL ill_idle busy=%b nick=%0d dime=%0d exp 0/0/0",
               bus.o_busy, nick_n - n0, dime_n - d0);
    end
  endtask

  task automatic test_random();
    int   code, owed, n, d;
    logic exp_err, de, dime;
    bit   first;
    for (int s = 0; s < 25; s++) begin
      code = $urandom_range(0, 7);
      owed = (code <= 4) ? code : 0;
      exp_err = code > 4;
      de = 1'($urandom_range(0, 1));
      bus.i_dime_empty = de;
      sale(code);
      checks++;
      if (bus.o_vend !== 1'b1 || bus.o_err !== exp_err ||
          bus.o_remaining !== 3'(owed)) begin
        failures++;
        $display("FAIL rnd_sale code=%0d vend=%b err=%b rem=%0d exp 1/%b/%0d",
                 code, bus.o_vend, bus.o_err, bus.o_remaining, exp_err, owed);
      end
      if (owed == 0) begin
        tick();
        checks++;
        if (bus.o_done !== 1'b1) begin
          failures++;
          $display("FAIL rnd_zero_done got=%b exp=1", bus.o_done);
        end
      end
      first = 1'b1;
      while (owed > 0) begin
        n = 0;
        while (!(bus.o_nickel_req || bus.o_dime_req) && n < 40) begin
          bus.i_hopper_ack = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        bus.i_hopper_ack = 1'b0;
        checks++;
        if (n != (first ? 1 : GAP)) begin
          failures++;
          $display("FAIL rnd_wait got=%0d exp=%0d", n, first ? 1 : GAP);
        end
        dime = (owed >= 2) && !de;
        checks++;
        if ({bus.o_dime_req, bus.o_nickel_req} !== {dime, !dime}) begin
          failures++;
          $display("FAIL rnd_coin got=%b exp=%b",
                   {bus.o_dime_req, bus.o_nickel_req}, {dime, !dime});
        end
        d = $urandom_range(0, 3);
        repeat (d) tick();
        bus.i_hopper_ack = 1'b1;
        tick();
        bus.i_hopper_ack = 1'b0;
        owed -= dime ? 2 : 1;
        de = 1'($urandom_range(0, 1));
        bus.i_dime_empty = de;
        checks++;
        if (bus.o_nickel_req !== 1'b0 || bus.o_dime_req !== 1'b0 ||
            bus.o_remaining !== 3'(owed) || bus.o_done !== (owed == 0)) begin
          failures++;
          $display("FAIL rnd_ack req=%b%b rem=%0d done=%b exp 00/%0d/%b",
                   bus.o_dime_req, bus.o_nickel_req, bus.o_remaining,
                   bus.o_done, owed, owed == 0);
        end
        first = 1'b0;
      end
      tick();
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_fault !== 1'b0) begin
        failures++;
        $display("FAIL rnd_idle busy=%b fault=%b exp 0/0",
                 bus.o_busy, bus.o_fault);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.i_dime_empty = 1'b0;
    sale(1);
    tick();
    n = 0;
    while (bus.o_nickel_req && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n != MW) begin
      failures++;
      $display("FAIL to_wait got=%0d exp=%0d", n, MW);
    end
    checks++;
    if ({bus.o_done, bus.o_fault, bus.o_remaining} !== 5'b11_000) begin
      failures++;
      $display("FAIL to_done got=%b exp=11000",
               {bus.o_done, bus.o_fault, bus.o_remaining});
    end
    repeat (5) tick();
    checks++;
    if ({bus.o_fault, bus.o_busy} !== 2'b10) begin
      failures++;
      $display("FAIL to_sticky got=%b exp=10", {bus.o_fault, bus.o_busy});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_fault !== 1'b0) begin
      failures++;
      $display("FAIL to_reset got=%b exp=0", bus.o_fault);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    bus.i_dime_empty = 1'b0;
    sale(1);
    repeat (40) tick();
    checks++;
    if ({bus.o_nickel_req, bus.o_fault, bus.o_done} !== 3'b100) begin
      failures++;
      $display("FAIL nto_hold got=%b exp=100",
               {bus.o_nickel_req, bus.o_fault, bus.o_done});
    end
    run_auto(50, ok);
    checks++;
    if (!ok || bus.o_fault !== 1'b0) begin
      failures++;
      $display("FAIL nto_finish ok=%0d fault=%b exp 1/0", ok, bus.o_fault);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus.i_dime_empty = 1'b0;
    sale(2);
    tick();
    checks++;
    if (bus.o_dime_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_req got=%b exp=1", bus.o_dime_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=0", outs());
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (outs() !== 11'd0) begin
      failures++;
      $display("FAIL mid_after got=%b exp=0", outs());
    end
  endtask

  initial begin
    test_reset();
    test_code3();
    test_nodime();
    test_zero_then_sale();
    test_overflow();
    test_back_to_back();
    test_illegal();
    test_random();
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
